// File: rtl/soft_error_handler_if.sv
// Stream and retry handshake between the parity checker, the soft-error
// handler and the downstream consumer. The handler connects to the slave
// modport. The bench or the surrounding logic connects to the master modport.
interface soft_error_handler_if #(
    parameter int DATA_SIZE = 32
);
    logic                 in_valid;
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_error;
    logic                 in_ready;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_ready;
    logic                 retry_req;
    logic                 retry_ack;

    modport slave (
        input  in_valid, in_data, in_error, out_ready, retry_ack,
        output in_ready, out_valid, out_data, retry_req
    );

    modport master (
        output in_valid, in_data, in_error, out_ready, retry_ack,
        input  in_ready, out_valid, out_data, retry_req
    );
endinterface

// File: rtl/soft_error_handler.sv
// Soft-error handler. It passes clean words downstream through a one-entry
// output register. Each errored word is dropped and counted, and upstream is
// asked to resend it. When THRESHOLD errored words arrive back to back, a
// sticky alarm is raised, and only the clear input removes it.
// Optional feature: define SOFT_ERR_CAPTURE_EN to add the err_data output.
// err_data holds the first errored word seen since reset or clear.
module soft_error_handler #(
    parameter int DATA_SIZE = 32,
    parameter int ERR_CNT_W = 8,
    parameter int THRESHOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soft_error_handler_if.slave  bus,
    input  logic                 clear,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 alarm
`ifdef SOFT_ERR_CAPTURE_EN
    ,
    output logic [DATA_SIZE-1:0] err_data
`endif
);

    localparam int          CONS_W   = 4;
    localparam logic [CONS_W-1:0] THRESH_C = CONS_W'(THRESHOLD);

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        RETRY = 2'd1,
        ALARM = 2'd2
    } state_e;

    state_e                 state_q,     state_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]   out_data_q,  out_data_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic [CONS_W-1:0]      consec_q,    consec_d;
    logic                   alarm_q,     alarm_d;
    logic                   retry_req_q, retry_req_d;
`ifdef SOFT_ERR_CAPTURE_EN
    logic [DATA_SIZE-1:0]   err_data_q,  err_data_d;
`endif

    logic                   in_ready;
    logic                   accept;
    logic [CONS_W-1:0]      consec_inc;

    // A new word may enter only in PASS, and only if the output register is
    // empty or is being drained in this cycle.
    assign in_ready   = (state_q == PASS) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready;
    assign consec_inc = consec_q + CONS_W'(1);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.retry_req = retry_req_q;
    assign err_count     = err_count_q;
    assign alarm         = alarm_q;
`ifdef SOFT_ERR_CAPTURE_EN
    assign err_data      = err_data_q;
`endif

    // Next-state logic: output drain, accept handling, retry handshake and clear.
    always_comb begin
        // NOTE: every _d signal gets a hold value first, so a path that does not
        // assign it cannot infer a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_count_d = err_count_q;
        consec_d    = consec_q;
        alarm_d     = alarm_q;
        retry_req_d = retry_req_q;
`ifdef SOFT_ERR_CAPTURE_EN
        err_data_d  = err_data_q;
`endif

        // Downstream takes the held word. clear does not touch this path.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            // clear overrides a same-cycle accept and retry_ack. The word
            // offered in this cycle is discarded.
            state_d     = PASS;
            err_count_d = '0;
            consec_d    = '0;
            alarm_d     = 1'b0;
            retry_req_d = 1'b0;
`ifdef SOFT_ERR_CAPTURE_EN
            err_data_d  = '0;
`endif
        end else begin
            unique case (state_q)
                PASS: begin
                    if (accept) begin
                        if (!bus.in_error) begin
                            out_valid_d = 1'b1;
                            out_data_d  = bus.in_data;
                            consec_d    = '0;
                        end else begin
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + ERR_CNT_W'(1);
                            end
                            consec_d = consec_inc;
`ifdef SOFT_ERR_CAPTURE_EN
                            // The counter saturates and never wraps, so zero
                            // means no error has been seen since reset or clear.
                            if (err_count_q == '0) begin
                                err_data_d = bus.in_data;
                            end
`endif
                            if (consec_inc == THRESH_C) begin
                                state_d = ALARM;
                                alarm_d = 1'b1;
                            end else begin
                                state_d     = RETRY;
                                retry_req_d = 1'b1;
                            end
                        end
                    end
                end
                RETRY: begin
                    if (bus.retry_ack) begin
                        state_d     = PASS;
                        retry_req_d = 1'b0;
                    end
                end
                ALARM: begin
                    // Only clear leaves ALARM. retry_ack and in_valid are ignored here.
                    retry_req_d = 1'b0;
                end
                default: begin
                    state_d = PASS;
                end
            endcase
        end
    end

    // State and datapath registers, with asynchronous reset to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        if (!reset_n) begin
            state_q     <= PASS;
            out_valid_q <= 1'b0;
            // NOTE: the data register is reset as well, because out_data must
            // read 0 while reset is asserted.
            out_data_q  <= '0;
            err_count_q <= '0;
            consec_q    <= '0;
            alarm_q     <= 1'b0;
            retry_req_q <= 1'b0;
`ifdef SOFT_ERR_CAPTURE_EN
            err_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_count_q <= err_count_d;
            consec_q    <= consec_d;
            alarm_q     <= alarm_d;
            retry_req_q <= retry_req_d;
`ifdef SOFT_ERR_CAPTURE_EN
            err_data_q  <= err_data_d;
`endif
        end
    end

endmodule
